// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and helpers for the two-port Wishbone bus arbiter.
// Optional feature macro used by the arbiter: MEM_ARBITER_ROUND_ROBIN_EN.
package mem_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_S1 = 2'd1,
    GRANT_S2 = 2'd2,
    DRAIN    = 2'd3
  } arb_state_t;

  // Port identifiers (also the encoding of the last-grant bit)
  localparam logic PORT_S1 = 1'b0;
  localparam logic PORT_S2 = 1'b1;

  // Choose the port to grant from IDLE. On a tie, prefer_s1 selects s1,
  // otherwise s2 wins. With a single requester that requester wins.
  function automatic logic arb_pick(input logic s1_req, input logic s2_req,
                                    input logic prefer_s1);
    logic port;
    if (s1_req && s2_req) begin
      port = prefer_s1 ? PORT_S1 : PORT_S2;
    end else if (s2_req) begin
      port = PORT_S2;
    end else begin
      port = PORT_S1;
    end
    return port;
  endfunction

endpackage

// File: rtl/arb_txn_counter.sv
// arb_txn_counter: saturating up/down count of bus requests that were accepted
// by the slave but not yet acknowledged. A decrement at zero is ignored and an
// increment at the ceiling is ignored; a simultaneous increment and decrement
// leaves the count unchanged.
module arb_txn_counter #(
  parameter  int MAX_OUTSTANDING = 2,
  localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_empty,
  output logic o_zero_next
);

  localparam logic [CW-1:0] C_MAX  = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] C_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] C_ONE  = CW'(32'd1);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          w_inc_eff;
  logic          w_dec_eff;

  // Ignore a decrement with nothing outstanding and an increment when full
  assign w_dec_eff = i_dec & (r_count != C_ZERO);
  assign w_inc_eff = i_inc & (r_count != C_MAX);

  // Next count from the effective increment/decrement pair
  always_comb begin
    w_count_next = r_count;
    if (w_inc_eff && !w_dec_eff) begin
      w_count_next = r_count + C_ONE;
    end else if (!w_inc_eff && w_dec_eff) begin
      w_count_next = r_count - C_ONE;
    end else begin
      w_count_next = r_count;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= C_ZERO;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_full      = (r_count == C_MAX);
  assign o_empty     = (r_count == C_ZERO);
  assign o_zero_next = (w_count_next == C_ZERO);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: pipelined Wishbone B4 arbiter sharing one master bus between the
// instruction-fetch port (s1, read-only) and the load/store port (s2).
// One port owns the bus per bus cycle; outstanding requests are counted so that
// acknowledges left over from an abandoned cycle are drained, not forwarded.
// Optional feature: define MEM_ARBITER_ROUND_ROBIN_EN to alternate the winner
// of simultaneous requests; by default s2 always wins a tie.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // fetch port (read-only)
  input  logic [31:0] s1_wb_adr_i,
  output logic [31:0] s1_wb_dat_o,
  input  logic [3:0]  s1_wb_sel_i,
  input  logic        s1_wb_stb_i,
  output logic        s1_wb_ack_o,
  input  logic        s1_wb_cyc_i,
  output logic        s1_wb_stall_o,
  // load/store port
  input  logic [31:0] s2_wb_adr_i,
  output logic [31:0] s2_wb_dat_o,
  input  logic [31:0] s2_wb_dat_i,
  input  logic        s2_wb_we_i,
  input  logic [3:0]  s2_wb_sel_i,
  input  logic        s2_wb_stb_i,
  output logic        s2_wb_ack_o,
  input  logic        s2_wb_cyc_i,
  output logic        s2_wb_stall_o,
  // shared master bus
  output logic [31:0] m_wb_adr_o,
  input  logic [31:0] m_wb_dat_i,
  output logic [31:0] m_wb_dat_o,
  output logic        m_wb_we_o,
  output logic [3:0]  m_wb_sel_o,
  output logic        m_wb_stb_o,
  input  logic        m_wb_ack_i,
  output logic        m_wb_cyc_o,
  input  logic        m_wb_stall_i
);

  arb_state_t r_state;

  logic w_accept;
  logic w_full;
  logic w_empty;
  logic w_zero_next;
  logic w_prefer_s1;
  logic w_pick;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // Port granted on the most recent IDLE->GRANT transition
  logic r_last_grant;
  assign w_prefer_s1 = (r_last_grant == PORT_S2);
`else
  assign w_prefer_s1 = 1'b0;
`endif

  assign w_pick = arb_pick(s1_wb_cyc_i, s2_wb_cyc_i, w_prefer_s1);

  // A request is accepted when it is presented and the slave does not stall
  assign w_accept = m_wb_stb_o & ~m_wb_stall_i;

  // Read data goes to both ports; only the owner sees an ack
  assign s1_wb_dat_o = m_wb_dat_i;
  assign s2_wb_dat_o = m_wb_dat_i;

  arb_txn_counter #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_txn_counter (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_inc      (w_accept),
    .i_dec      (m_wb_ack_i),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_zero_next(w_zero_next)
  );

  // Arbitration FSM: grant from IDLE, release on cyc drop, drain orphaned acks
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      r_last_grant <= PORT_S2;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (s1_wb_cyc_i || s2_wb_cyc_i) begin
            r_state <= (w_pick == PORT_S2) ? GRANT_S2 : GRANT_S1;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            r_last_grant <= w_pick;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        GRANT_S1: begin
          if (!s1_wb_cyc_i) begin
            r_state <= w_zero_next ? IDLE : DRAIN;
          end else begin
            r_state <= GRANT_S1;
          end
        end
        GRANT_S2: begin
          if (!s2_wb_cyc_i) begin
            r_state <= w_zero_next ? IDLE : DRAIN;
          end else begin
            r_state <= GRANT_S2;
          end
        end
        DRAIN: begin
          // No new requests are issued here, so empty implies zero next
          if (w_zero_next || w_empty) begin
            r_state <= IDLE;
          end else begin
            r_state <= DRAIN;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Steer the owning port onto the master bus and route stall/ack back to it
  always_comb begin
    m_wb_adr_o    = 32'd0;
    m_wb_dat_o    = 32'd0;
    m_wb_we_o     = 1'b0;
    m_wb_sel_o    = 4'd0;
    m_wb_stb_o    = 1'b0;
    m_wb_cyc_o    = 1'b0;
    s1_wb_ack_o   = 1'b0;
    s1_wb_stall_o = 1'b1;
    s2_wb_ack_o   = 1'b0;
    s2_wb_stall_o = 1'b1;
    case (r_state)
      IDLE: begin
        m_wb_cyc_o = 1'b0;
      end
      GRANT_S1: begin
        // fetch port never writes
        m_wb_adr_o    = s1_wb_adr_i;
        m_wb_sel_o    = s1_wb_sel_i;
        m_wb_cyc_o    = s1_wb_cyc_i;
        m_wb_stb_o    = s1_wb_stb_i & ~w_full;
        s1_wb_stall_o = m_wb_stall_i | w_full;
        s1_wb_ack_o   = m_wb_ack_i;
      end
      GRANT_S2: begin
        m_wb_adr_o    = s2_wb_adr_i;
        m_wb_dat_o    = s2_wb_dat_i;
        m_wb_we_o     = s2_wb_we_i;
        m_wb_sel_o    = s2_wb_sel_i;
        m_wb_cyc_o    = s2_wb_cyc_i;
        m_wb_stb_o    = s2_wb_stb_i & ~w_full;
        s2_wb_stall_o = m_wb_stall_i | w_full;
        s2_wb_ack_o   = m_wb_ack_i;
      end
      DRAIN: begin
        // keep the cycle open so the slave can finish; swallow its acks
        m_wb_cyc_o = 1'b1;
      end
      default: begin
        m_wb_cyc_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic for mem_arbiter,
// checked every cycle against a transaction-level reference model
// (owner / drain flag / queue of outstanding requests).
module tb_mem_arbiter;

  localparam int MAXO = 2;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] s1_wb_adr_i, s1_wb_dat_o;
  logic [3:0]  s1_wb_sel_i;
  logic        s1_wb_stb_i, s1_wb_ack_o, s1_wb_cyc_i, s1_wb_stall_o;
  logic [31:0] s2_wb_adr_i, s2_wb_dat_o, s2_wb_dat_i;
  logic        s2_wb_we_i;
  logic [3:0]  s2_wb_sel_i;
  logic        s2_wb_stb_i, s2_wb_ack_o, s2_wb_cyc_i, s2_wb_stall_o;
  logic [31:0] m_wb_adr_o, m_wb_dat_i, m_wb_dat_o;
  logic        m_wb_we_o;
  logic [3:0]  m_wb_sel_o;
  logic        m_wb_stb_o, m_wb_ack_i, m_wb_cyc_o, m_wb_stall_i;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s1_wb_adr_i(s1_wb_adr_i), .s1_wb_dat_o(s1_wb_dat_o), .s1_wb_sel_i(s1_wb_sel_i),
    .s1_wb_stb_i(s1_wb_stb_i), .s1_wb_ack_o(s1_wb_ack_o), .s1_wb_cyc_i(s1_wb_cyc_i),
    .s1_wb_stall_o(s1_wb_stall_o),
    .s2_wb_adr_i(s2_wb_adr_i), .s2_wb_dat_o(s2_wb_dat_o), .s2_wb_dat_i(s2_wb_dat_i),
    .s2_wb_we_i(s2_wb_we_i), .s2_wb_sel_i(s2_wb_sel_i), .s2_wb_stb_i(s2_wb_stb_i),
    .s2_wb_ack_o(s2_wb_ack_o), .s2_wb_cyc_i(s2_wb_cyc_i), .s2_wb_stall_o(s2_wb_stall_o),
    .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_i(m_wb_dat_i), .m_wb_dat_o(m_wb_dat_o),
    .m_wb_we_o(m_wb_we_o), .m_wb_sel_o(m_wb_sel_o), .m_wb_stb_o(m_wb_stb_o),
    .m_wb_ack_i(m_wb_ack_i), .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stall_i(m_wb_stall_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Single comparison point: count it, report a mismatch
  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int mdl_owner;        // 0 = nobody, 1 = s1, 2 = s2
  bit mdl_drain;        // previous owner left, slave still owes acks
  int mdl_pend[$];      // one entry per accepted, unacknowledged request
  int mdl_last;         // port granted most recently (round-robin memory)

  logic        e_cyc, e_stb, e_we, e_ack1, e_ack2, e_stall1, e_stall2;
  logic [31:0] e_adr, e_dat;
  logic [3:0]  e_sel;

  task automatic model_reset();
    mdl_owner = 0;
    mdl_drain = 1'b0;
    mdl_pend.delete();
    mdl_last  = 2;
  endtask

  task automatic model_outputs();
    bit room;
    room     = (mdl_pend.size() < MAXO);
    e_cyc    = 1'b0; e_stb = 1'b0; e_we = 1'b0;
    e_adr    = 32'd0; e_dat = 32'd0; e_sel = 4'd0;
    e_ack1   = 1'b0; e_ack2 = 1'b0; e_stall1 = 1'b1; e_stall2 = 1'b1;
    if (mdl_drain) begin
      e_cyc = 1'b1;
    end else if (mdl_owner == 1) begin
      e_cyc    = s1_wb_cyc_i; e_adr = s1_wb_adr_i; e_sel = s1_wb_sel_i;
      e_stb    = s1_wb_stb_i && room;
      e_stall1 = m_wb_stall_i || !room;
      e_ack1   = m_wb_ack_i;
    end else if (mdl_owner == 2) begin
      e_cyc    = s2_wb_cyc_i; e_adr = s2_wb_adr_i; e_sel = s2_wb_sel_i;
      e_we     = s2_wb_we_i;  e_dat = s2_wb_dat_i;
      e_stb    = s2_wb_stb_i && room;
      e_stall2 = m_wb_stall_i || !room;
      e_ack2   = m_wb_ack_i;
    end
  endtask

  task automatic check_outputs();
    model_outputs();
    check_val("m_cyc",    m_wb_cyc_o,    e_cyc);
    check_val("m_stb",    m_wb_stb_o,    e_stb);
    check_val("m_we",     m_wb_we_o,     e_we);
    check_val("m_adr",    m_wb_adr_o,    e_adr);
    check_val("m_dat",    m_wb_dat_o,    e_dat);
    check_val("m_sel",    m_wb_sel_o,    e_sel);
    check_val("s1_ack",   s1_wb_ack_o,   e_ack1);
    check_val("s2_ack",   s2_wb_ack_o,   e_ack2);
    check_val("s1_stall", s1_wb_stall_o, e_stall1);
    check_val("s2_stall", s2_wb_stall_o, e_stall2);
    check_val("s1_dat",   s1_wb_dat_o,   m_wb_dat_i);
    check_val("s2_dat",   s2_wb_dat_o,   m_wb_dat_i);
  endtask

  // Advance the model by one clock using the inputs of the ending cycle
  task automatic model_update();
    int want;
    bit accept;
    if (rst_i) begin
      model_reset();
    end else begin
      model_outputs();
      accept = e_stb && !m_wb_stall_i;
      if (m_wb_ack_i && mdl_pend.size() > 0) void'(mdl_pend.pop_front());
      if (accept) mdl_pend.push_back(mdl_owner);
      if (mdl_drain) begin
        if (mdl_pend.size() == 0) mdl_drain = 1'b0;
      end else if (mdl_owner == 0) begin
        if (s1_wb_cyc_i && s2_wb_cyc_i) want = (RR && mdl_last == 2) ? 1 : 2;
        else if (s2_wb_cyc_i)           want = 2;
        else if (s1_wb_cyc_i)           want = 1;
        else                            want = 0;
        if (want != 0) begin
          mdl_owner = want;
          mdl_last  = want;
        end
      end else if ((mdl_owner == 1 && !s1_wb_cyc_i) || (mdl_owner == 2 && !s2_wb_cyc_i)) begin
        mdl_owner = 0;
        mdl_drain = (mdl_pend.size() > 0);
      end
    end
  endtask

  // One clock: check at the falling edge, update the model at the rising edge
  task automatic tick();
    @(negedge clk_i);
    check_outputs();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic idle_all();
    s1_wb_adr_i = 32'd0; s1_wb_sel_i = 4'd0; s1_wb_stb_i = 1'b0; s1_wb_cyc_i = 1'b0;
    s2_wb_adr_i = 32'd0; s2_wb_dat_i = 32'd0; s2_wb_we_i = 1'b0; s2_wb_sel_i = 4'd0;
    s2_wb_stb_i = 1'b0;  s2_wb_cyc_i = 1'b0;
    m_wb_dat_i  = 32'd0; m_wb_ack_i = 1'b0; m_wb_stall_i = 1'b0;
  endtask

  initial begin
    // ---- reset: requests present but reset dominates ----
    rst_i = 1'b1;
    idle_all();
    s1_wb_cyc_i = 1'b1; s2_wb_cyc_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    model_reset();
    check_val("rst_m_cyc",    m_wb_cyc_o,    1'b0);
    check_val("rst_m_stb",    m_wb_stb_o,    1'b0);
    check_val("rst_m_adr",    m_wb_adr_o,    32'd0);
    check_val("rst_s1_stall", s1_wb_stall_o, 1'b1);
    check_val("rst_s2_stall", s2_wb_stall_o, 1'b1);
    tick();
    rst_i = 1'b0;
    idle_all();
    tick();

    // ---- s1 single read ----
    s1_wb_cyc_i = 1'b1; s1_wb_stb_i = 1'b1; s1_wb_adr_i = 32'h0000_1000; s1_wb_sel_i = 4'hF;
    #1;
    check_val("s1_rd_latency", m_wb_cyc_o, 1'b0);
    tick();
    check_val("s1_rd_adr", m_wb_adr_o, 32'h0000_1000);
    check_val("s1_rd_stb", m_wb_stb_o, 1'b1);
    tick();
    s1_wb_stb_i = 1'b0;
    tick();
    m_wb_ack_i = 1'b1; m_wb_dat_i = 32'hDEAD_BEEF;
    #1;
    check_val("s1_rd_ack",    s1_wb_ack_o, 1'b1);
    check_val("s1_rd_dat",    s1_wb_dat_o, 32'hDEAD_BEEF);
    check_val("s1_rd_s2_ack", s2_wb_ack_o, 1'b0);
    tick();
    m_wb_ack_i = 1'b0; s1_wb_cyc_i = 1'b0;
    tick();
    check_val("s1_rd_release", m_wb_cyc_o, 1'b0);

    // ---- simultaneous requests ----
    s1_wb_cyc_i = 1'b1; s2_wb_cyc_i = 1'b1;
    s1_wb_adr_i = 32'h0000_2000; s2_wb_adr_i = 32'h0000_3000;
    s1_wb_sel_i = 4'hF; s2_wb_sel_i = 4'hF;
    tick();
    check_val("tie1_winner_adr", m_wb_adr_o, 32'h0000_3000);
    check_val("tie1_s1_stalled", s1_wb_stall_o, 1'b1);
    tick();
    check_val("tie1_s1_still_stalled", s1_wb_stall_o, 1'b1);
    s2_wb_cyc_i = 1'b0;
    tick();
    tick();
    check_val("tie1_s1_granted_adr", m_wb_adr_o, 32'h0000_2000);
    check_val("tie1_s1_unstalled", s1_wb_stall_o, 1'b0);
    s1_wb_cyc_i = 1'b0;
    tick();
    s2_wb_cyc_i = 1'b1;
    tick();
    s2_wb_cyc_i = 1'b0;
    tick();
    s1_wb_cyc_i = 1'b1; s2_wb_cyc_i = 1'b1;
    tick();
    check_val("tie2_winner_adr", m_wb_adr_o, RR ? 32'h0000_2000 : 32'h0000_3000);
    idle_all();
    tick();
    tick();

    // ---- outstanding limit: three back-to-back writes from s2 ----
    s2_wb_cyc_i = 1'b1; s2_wb_stb_i = 1'b1; s2_wb_we_i = 1'b1; s2_wb_sel_i = 4'hF;
    s2_wb_adr_i = 32'h0000_4000; s2_wb_dat_i = 32'h1111_1111;
    tick();
    tick();
    s2_wb_adr_i = 32'h0000_4004; s2_wb_dat_i = 32'h2222_2222;
    tick();
    s2_wb_adr_i = 32'h0000_4008; s2_wb_dat_i = 32'h3333_3333;
    #1;
    check_val("lim_s2_stall", s2_wb_stall_o, 1'b1);
    check_val("lim_m_stb",    m_wb_stb_o,    1'b0);
    tick();
    m_wb_ack_i = 1'b1;
    #1;
    check_val("lim_stall_during_ack", s2_wb_stall_o, 1'b1);
    tick();
    m_wb_ack_i = 1'b0;
    #1;
    check_val("lim_s2_resume", s2_wb_stall_o, 1'b0);
    check_val("lim_m_stb_resume", m_wb_stb_o, 1'b1);
    check_val("lim_m_dat", m_wb_dat_o, 32'h3333_3333);
    tick();
    s2_wb_stb_i = 1'b0; m_wb_ack_i = 1'b1;
    tick();
    tick();
    m_wb_ack_i = 1'b0; s2_wb_cyc_i = 1'b0;
    tick();

    // ---- abandoned s1 cycle drains, then pending s2 is granted ----
    idle_all();
    s1_wb_cyc_i = 1'b1; s1_wb_stb_i = 1'b1; s1_wb_adr_i = 32'h0000_5000; s1_wb_sel_i = 4'hF;
    tick();
    tick();
    s1_wb_adr_i = 32'h0000_5004;
    tick();
    s1_wb_cyc_i = 1'b0; s1_wb_stb_i = 1'b0;
    s2_wb_cyc_i = 1'b1; s2_wb_adr_i = 32'h0000_6000; s2_wb_sel_i = 4'hF;
    tick();
    check_val("drain_m_cyc", m_wb_cyc_o, 1'b1);
    check_val("drain_m_stb", m_wb_stb_o, 1'b0);
    m_wb_ack_i = 1'b1;
    #1;
    check_val("drain_s1_ack", s1_wb_ack_o, 1'b0);
    check_val("drain_s2_ack", s2_wb_ack_o, 1'b0);
    tick();
    tick();
    m_wb_ack_i = 1'b0;
    #1;
    check_val("drain_exit_idle", m_wb_cyc_o, 1'b0);
    tick();
    check_val("drain_s2_granted_cyc", m_wb_cyc_o, 1'b1);
    check_val("drain_s2_granted_adr", m_wb_adr_o, 32'h0000_6000);
    check_val("drain_s2_unstalled", s2_wb_stall_o, 1'b0);
    s2_wb_cyc_i = 1'b0;
    tick();

    // ---- reset with two writes outstanding ----
    idle_all();
    s2_wb_cyc_i = 1'b1; s2_wb_stb_i = 1'b1; s2_wb_adr_i = 32'h0000_7000; s2_wb_sel_i = 4'hF;
    tick();
    tick();
    tick();
    s2_wb_stb_i = 1'b0;
    #1;
    check_val("mrst_full_stall", s2_wb_stall_o, 1'b1);
    rst_i = 1'b1; s2_wb_cyc_i = 1'b0;
    tick();
    rst_i = 1'b0; m_wb_ack_i = 1'b1;
    #1;
    check_val("mrst_idle_cyc", m_wb_cyc_o, 1'b0);
    check_val("mrst_ack_blocked", s2_wb_ack_o, 1'b0);
    tick();
    m_wb_ack_i = 1'b0;
    s2_wb_cyc_i = 1'b1; s2_wb_stb_i = 1'b1;
    tick();
    check_val("mrst_count_cleared_stb", m_wb_stb_o, 1'b1);
    idle_all();
    tick();

    // ---- randomized traffic ----
    for (int i = 0; i < 3000; i++) begin
      rst_i = ($urandom_range(0, 199) == 0);
      if (s1_wb_cyc_i) s1_wb_cyc_i = ($urandom_range(0, 9) != 0);
      else             s1_wb_cyc_i = ($urandom_range(0, 3) == 0);
      s1_wb_stb_i = s1_wb_cyc_i && ($urandom_range(0, 1) == 1);
      s1_wb_adr_i = $urandom;
      s1_wb_sel_i = 4'($urandom);
      if (s2_wb_cyc_i) s2_wb_cyc_i = ($urandom_range(0, 9) != 0);
      else             s2_wb_cyc_i = ($urandom_range(0, 3) == 0);
      s2_wb_stb_i = s2_wb_cyc_i && ($urandom_range(0, 1) == 1);
      s2_wb_we_i  = ($urandom_range(0, 1) == 1);
      s2_wb_adr_i = $urandom;
      s2_wb_dat_i = $urandom;
      s2_wb_sel_i = 4'($urandom);
      m_wb_stall_i = ($urandom_range(0, 3) == 0);
      m_wb_ack_i   = ($urandom_range(0, 2) == 0);
      m_wb_dat_i   = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Pipelined Wishbone B4 arbiter that shares the processor's single external bus between the instruction-fetch port (s1, read-only) and the load/store port (s2). Sits between fetch/loadstore and the core's top-level bus outputs. Grants one port per bus cycle, tracks outstanding requests, and drains orphaned acknowledges after an aborted cycle.

Parameters:
MAX_OUTSTANDING, 2, maximum accepted-but-unacknowledged requests on the master port (>=1); counter width is $clog2(MAX_OUTSTANDING+1).

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
s1_wb_adr_i  in  32  fetch address
s1_wb_dat_o  out  32  read data (m_wb_dat_i broadcast)
s1_wb_sel_i  in  4  fetch byte select
s1_wb_stb_i  in  1  fetch strobe
s1_wb_ack_o  out  1  fetch acknowledge
s1_wb_cyc_i  in  1  fetch cycle
s1_wb_stall_o  out  1  fetch stall
s2_wb_adr_i  in  32  load/store address
s2_wb_dat_o  out  32  read data (m_wb_dat_i broadcast)
s2_wb_dat_i  in  32  store data
s2_wb_we_i  in  1  write enable
s2_wb_sel_i  in  4  byte select
s2_wb_stb_i  in  1  strobe
s2_wb_ack_o  out  1  acknowledge
s2_wb_cyc_i  in  1  cycle
s2_wb_stall_o  out  1  stall
m_wb_adr_o  out  32  bus address
m_wb_dat_i  in  32  bus read data
m_wb_dat_o  out  32  bus write data
m_wb_we_o  out  1  bus write enable
m_wb_sel_o  out  4  bus byte select
m_wb_stb_o  out  1  bus strobe
m_wb_ack_i  in  1  bus acknowledge
m_wb_cyc_o  out  1  bus cycle
m_wb_stall_i  in  1  bus stall

Behaviour:
- States: IDLE, GRANT_S1, GRANT_S2, DRAIN. Registered state; outputs are combinational from state plus inputs.
- Reset: state=IDLE, outstanding count=0. In IDLE: m_wb_cyc_o=0, m_wb_stb_o=0, m_wb_we_o=0, m_wb_adr_o/dat_o/sel_o=0, s1/s2 ack=0, s1/s2 stall=1.
- IDLE: s2_wb_cyc_i=1 -> GRANT_S2; else s1_wb_cyc_i=1 -> GRANT_S1 (s2 priority). Arbitration latency is one cycle: a request first reaches the master port the cycle after cyc rises.
- GRANT_Sx: m_* mirrors port x (adr/sel/stb/cyc). For s1, m_wb_we_o=0 and m_wb_dat_o=0. m_wb_stb_o = stb_x & (count<MAX_OUTSTANDING). stall_x = m_wb_stall_i | (count==MAX_OUTSTANDING). ack_x = m_wb_ack_i. Non-granted port: stall=1, ack=0.
- Counter: +1 on accept (m_wb_stb_o & ~m_wb_stall_i), -1 on m_wb_ack_i. Simultaneous accept and ack -> unchanged. An ack with count=0 is ignored (no underflow).
- Release: cyc_x=0 with count==0, or count==1 with m_wb_ack_i this cycle -> IDLE. cyc_x=0 with acks still pending -> DRAIN.
- DRAIN: m_wb_cyc_o=1, m_wb_stb_o=0. Acks are consumed without being forwarded (both acks=0, both stalls=1). Exits to IDLE on the cycle count reaches 0.
- Reset asserted mid-transfer: immediate return to reset values; pending bus acks are discarded.
- s1_wb_dat_o and s2_wb_dat_o always equal m_wb_dat_i.

Optional Feature:
MEM_ARBITER_ROUND_ROBIN_EN
- Defined: a registered last_grant bit is set on every IDLE->GRANT transition. When both cyc inputs are high in IDLE, the port not granted last wins. Reset value: last_grant=s2, so s1 wins the first tie.
- Undefined: fixed s2 priority and no last_grant register.

Decomposition:
- Package mem_arbiter_pkg: arb_state_t enum (IDLE, GRANT_S1, GRANT_S2, DRAIN) and port-id constants PORT_S1=0, PORT_S2=1.
- Sub-module arb_txn_counter: saturating up/down counter with inc, dec, full, empty, zero_next outputs, parameterised by MAX_OUTSTANDING.

Test Plan:
- Reset: assert rst_i for 2 cycles -> all m_* outputs 0, s1/s2 stall=1, ack=0; afterwards count=0, state IDLE.
- s1 single read at 0x1000, slave acks 2 cycles after accept with data 0xDEADBEEF -> m_wb_adr_o=0x1000 one cycle after cyc; s1 ack=1 with dat=0xDEADBEEF; s2 ack stays 0.
- s1 and s2 raise cyc in the same cycle -> s2 is granted first, s1 is stalled until s2 cyc drops; with ROUND_ROBIN_EN, s1 wins a second simultaneous tie only if s2 won the previous one.
- MAX_OUTSTANDING=2, s2 issues 3 back-to-back writes with acks held off -> third request stalled (s2 stall=1, m_stb=0) until the first ack arrives.
- s1 issues 2 reads, drops cyc before any ack -> DRAIN with m_cyc=1; 2 acks are swallowed (s1 ack=0), then IDLE; a pending s2 is granted the following cycle.
- rst_i pulsed while count=2 in GRANT_S2 -> next cycle is IDLE with count=0; later m_wb_ack_i pulses do not reach s2_wb_ack_o.
